// File: rtl/random_choose_if.sv
// Bus bundle for the weighted random selector: draw enable, four weights,
// the LFSR seed and the registered segment choice.
interface random_choose_if #(
  parameter int WIDTH = 31
);
  logic             in_enable;
  logic [WIDTH:0]   in_weight0;
  logic [WIDTH:0]   in_weight1;
  logic [WIDTH:0]   in_weight2;
  logic [WIDTH:0]   in_weight3;
  logic [WIDTH:0]   in_seed;
  logic [1:0]       out_segment_number;

  modport master (
    output in_enable, in_weight0, in_weight1, in_weight2, in_weight3, in_seed,
    input  out_segment_number
  );

  modport slave (
    input  in_enable, in_weight0, in_weight1, in_weight2, in_weight3, in_seed,
    output out_segment_number
  );
endinterface

// File: rtl/random_choose.sv
// Weighted pseudo-random selector: a seeded 32-bit Galois LFSR scales the weight
// total and the scaled pick lands in one of four cumulative weight bins.
module random_choose #(
  parameter int WIDTH = 31
) (
  input  logic           in_clock,
  input  logic           in_reset,
  random_choose_if.slave bus
);
  localparam int TW = WIDTH + 3;
  localparam int PW = TW + 16;

  typedef enum logic {ST_UNSEEDED, ST_RUNNING} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            w_loadSeed;
  logic            w_advance;
  logic [31:0]     r_lfsr;
  logic [31:0]     w_lfsrNext;
  logic [31:0]     w_seed32;
  logic [31:0]     w_seedLoad;
  logic [1:0]      r_segment;
  logic [1:0]      w_segment;
  logic [TW-1:0]   w_total;
  logic [TW-1:0]   w_c0;
  logic [TW-1:0]   w_c1;
  logic [TW-1:0]   w_c2;
  logic [TW-1:0]   w_pick;
  logic [PW-1:0]   w_product;

  generate
    if (WIDTH >= 31) begin : g_seedTrunc
      assign w_seed32 = bus.in_seed[31:0];
    end else begin : g_seedExt
      assign w_seed32 = {{(31 - WIDTH){1'b0}}, bus.in_seed};
    end
  endgenerate

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  assign w_seedLoad = (w_seed32 == 32'h0) ? 32'h1 : w_seed32;
  assign w_lfsrNext = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);

  assign w_c0      = TW'(bus.in_weight0);
  assign w_c1      = w_c0 + TW'(bus.in_weight1);
  assign w_c2      = w_c1 + TW'(bus.in_weight2);
  assign w_total   = w_c2 + TW'(bus.in_weight3);
  assign w_product = PW'(r_lfsr[15:0]) * PW'(w_total);
  assign w_pick    = TW'(w_product >> 16);

  always_comb begin
    w_segment = 2'd3;
    if (w_total == '0) begin
      w_segment = 2'd0;
    end else if (w_pick < w_c0) begin
      w_segment = 2'd0;
    end else if (w_pick < w_c1) begin
      w_segment = 2'd1;
    end else if (w_pick < w_c2) begin
      w_segment = 2'd2;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_state <= ST_UNSEEDED;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The first edge out of reset only loads the seed; enable is ignored there.
  always_comb begin
    w_nextState = r_state;
    w_loadSeed  = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_UNSEEDED: begin
        w_loadSeed  = 1'b1;
        w_nextState = ST_RUNNING;
      end
      ST_RUNNING: begin
        w_advance = bus.in_enable;
      end
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_lfsr    <= 32'h0;
      r_segment <= 2'd0;
    end else if (w_loadSeed) begin
      r_lfsr <= w_seedLoad;
    end else if (w_advance) begin
      r_lfsr    <= w_lfsrNext;
      r_segment <= w_segment;
    end
  end

  assign bus.out_segment_number = r_segment;
endmodule

// File: tb/tb_random_choose.sv
// Scoreboard bench for random_choose: stimulus pushes expected segments, a
// monitor pops and compares after every enabled, seeded clock edge.
module tb_random_choose;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  int          total = 0;
  int          bad = 0;
  bit          seeded = 1'b0;
  logic [1:0]  sbq[$];
  logic [1:0]  lastPushed = 2'd0;
  logic [31:0] modelLfsr = 32'h1;
  logic [31:0] wt[4];
  int          segCount[4];

  random_choose_if #(.WIDTH(31)) bus ();

  random_choose #(.WIDTH(31)) dut (
    .in_clock (clock),
    .in_reset (resetN),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] expVal);
    total++;
    if (act !== expVal) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, expVal);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] stepModel(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) begin
      r[31] = ~r[31];
      r[21] = ~r[21];
      r[1]  = ~r[1];
      r[0]  = ~r[0];
    end
    return r;
  endfunction

  function automatic logic [1:0] drawModel(input logic [31:0] s);
    longint unsigned tot, pick, acc;
    tot = longint'(wt[0]) + longint'(wt[1]) + longint'(wt[2]) + longint'(wt[3]);
    if (tot == 0) return 2'd0;
    pick = (longint'(s[15:0]) * tot) >> 16;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      acc += longint'(wt[i]);
      if (pick < acc) return 2'(i);
    end
    return 2'd3;
  endfunction

  // Monitor: every enabled edge after seeding yields one draw to compare.
  always @(posedge clock) begin
    logic [1:0] expVal;
    if (resetN && bus.in_enable && seeded) begin
      #1;
      if (sbq.size() == 0) begin
        checkRange("sb_underflow", 0, 1, 1);
      end else begin
        expVal = sbq.pop_front();
        checkOutput("draw", bus.out_segment_number, expVal);
      end
      segCount[bus.out_segment_number]++;
    end
  end

  task automatic setWeights(input logic [31:0] a, b, c, d);
    wt[0] = a; wt[1] = b; wt[2] = c; wt[3] = d;
    bus.in_weight0 = a;
    bus.in_weight1 = b;
    bus.in_weight2 = c;
    bus.in_weight3 = d;
  endtask

  // Reset for one cycle with enable held high, then release and pass the seed edge.
  task automatic startRun(input logic [31:0] seed);
    @(negedge clock);
    resetN = 1'b0;
    seeded = 1'b0;
    bus.in_enable = 1'b1;
    bus.in_seed = seed;
    #1;
    checkOutput("reset_async", bus.out_segment_number, 2'd0);
    @(negedge clock);
    checkOutput("reset_hold", bus.out_segment_number, 2'd0);
    resetN = 1'b1;
    modelLfsr = (seed == 32'h0) ? 32'h1 : seed;
    @(negedge clock);
    checkOutput("seed_edge_hold", bus.out_segment_number, 2'd0);
    bus.in_enable = 1'b0;
    seeded = 1'b1;
  endtask

  task automatic applyStimulus(input int n, input bit fixed, input logic [1:0] fixedVal);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.in_enable = 1'b1;
      lastPushed = fixed ? fixedVal : drawModel(modelLfsr);
      sbq.push_back(lastPushed);
      modelLfsr = stepModel(modelLfsr);
    end
    @(negedge clock);
    bus.in_enable = 1'b0;
  endtask

  initial begin
    bus.in_enable = 1'b1;
    bus.in_seed = 32'h1;
    setWeights(32'd1, 32'd1, 32'd1, 32'd1);
    repeat (4) begin
      @(negedge clock);
      checkOutput("reset_held_low", bus.out_segment_number, 2'd0);
    end

    // Hand-computed: seed FFFF -> lfsr 0000FFFF, 80207FFC, 40103FFE, 20081FFF.
    startRun(32'h0000FFFF);
    applyStimulus(1, 1'b1, 2'd3);
    applyStimulus(1, 1'b1, 2'd1);
    applyStimulus(1, 1'b1, 2'd0);
    applyStimulus(1, 1'b1, 2'd0);
    repeat (3) begin
      @(negedge clock);
      checkOutput("hold_disabled", bus.out_segment_number, 2'd0);
    end

    startRun(32'h00008000);
    applyStimulus(1, 1'b1, 2'd2);
    startRun(32'h00004000);
    applyStimulus(1, 1'b1, 2'd1);
    startRun(32'h0);
    applyStimulus(1, 1'b1, 2'd0);

    setWeights(32'd1, 32'd0, 32'd0, 32'd1);
    startRun(32'h0000FFFF);
    applyStimulus(1, 1'b1, 2'd3);
    setWeights(32'd3, 32'd0, 32'd0, 32'd0);
    startRun(32'h0000FFFF);
    applyStimulus(1, 1'b1, 2'd0);
    setWeights(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    startRun(32'h0000FFFF);
    applyStimulus(1, 1'b1, 2'd3);

    setWeights(32'd0, 32'd0, 32'd7, 32'd0);
    startRun(32'h1);
    applyStimulus(40, 1'b1, 2'd2);
    setWeights(32'd0, 32'd0, 32'd0, 32'd0);
    applyStimulus(40, 1'b1, 2'd0);

    // Long weighted run with a five-cycle pause in the middle.
    setWeights(32'd2, 32'd4, 32'd2, 32'd0);
    startRun(32'h1);
    for (int i = 0; i < 4; i++) segCount[i] = 0;
    applyStimulus(5000, 1'b0, 2'd0);
    repeat (5) begin
      @(negedge clock);
      checkOutput("pause_hold", bus.out_segment_number, lastPushed);
    end
    applyStimulus(5000, 1'b0, 2'd0);
    checkRange("seg3_count", segCount[3], 0, 0);
    checkRange("seg0_count", segCount[0], 2200, 2800);
    checkRange("seg1_count", segCount[1], 4700, 5300);
    checkRange("seg2_count", segCount[2], 2200, 2800);

    // Seed 0 must behave as seed 1; seed 5 runs its own model sequence.
    setWeights(32'd1, 32'd1, 32'd1, 32'd1);
    startRun(32'h0);
    applyStimulus(64, 1'b0, 2'd0);
    startRun(32'h5);
    applyStimulus(64, 1'b0, 2'd0);

    // Reset after 100 draws; the same 100 draws must follow again.
    startRun(32'h1);
    applyStimulus(100, 1'b0, 2'd0);
    startRun(32'h1);
    applyStimulus(100, 1'b0, 2'd0);

    repeat (3) @(negedge clock);
    checkRange("sb_drained", sbq.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
